// File: rtl/wb_cfg_master.sv
// ---------------------------------------------------------------------------
// wb_cfg_master
//   Wishbone classic single-transfer bus master for the MAC register port.
//   It accepts one command (read/write, word address, byte selects, data),
//   runs exactly one Wishbone cycle, and returns one response (read data,
//   error flag, timeout flag) before it accepts the next command.
//
// Ports
//   wb_clk_i, wb_rst_i          bus clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_sel_i, cmd_dat_i        command payload (word address, byte selects)
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_dat_o, rsp_err_o,
//   rsp_timeout_o               response payload
//   m_wb_*                      Wishbone master pins (cyc always equals stb)
//   busy_o                      high whenever a command is in flight
// ---------------------------------------------------------------------------
module wb_cfg_master #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [9:0]  cmd_adr_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [11:2] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  output logic        busy_o
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  // Keep the counter at least one bit wide so a disabled timeout still elaborates.
  localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
  localparam logic TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             stb_q, stb_d;
  logic [9:0]       adr_q, adr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             rerr_q, rerr_d;
  logic             rto_q, rto_d;
  logic             term_s;

  // Next-state and next-output logic for the IDLE -> BUS -> RESP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stb_d    = stb_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    rvalid_d = rvalid_q;
    rdat_d   = rdat_q;
    rerr_d   = rerr_q;
    rto_d    = rto_q;
    term_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          state_d = S_BUS;
          cnt_d   = '0;
          stb_d   = 1'b1;
          adr_d   = cmd_adr_i;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          wdat_d  = cmd_we_i ? cmd_dat_i : 32'h0000_0000;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUS: begin
        // Priority: err beats ack, and either beats the timeout on the same edge.
        if (m_wb_err_i) begin
          term_s = 1'b1;
          rdat_d = 32'h0000_0000;
          rerr_d = 1'b1;
          rto_d  = 1'b0;
        end else if (m_wb_ack_i) begin
          term_s = 1'b1;
          rdat_d = we_q ? 32'h0000_0000 : m_wb_dat_i;
          rerr_d = 1'b0;
          rto_d  = 1'b0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          term_s = 1'b1;
          rdat_d = 32'h0000_0000;
          rerr_d = 1'b1;
          rto_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (term_s) begin
          state_d  = S_RESP;
          stb_d    = 1'b0;
          adr_d    = 10'h000;
          wdat_d   = 32'h0000_0000;
          sel_d    = 4'h0;
          we_d     = 1'b0;
          rvalid_d = 1'b1;
        end else begin
          state_d = S_BUS;
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
          rdat_d   = 32'h0000_0000;
          rerr_d   = 1'b0;
          rto_d    = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d  = S_IDLE;
        stb_d    = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase

    // Ready/busy are registered copies of the next state so they stay glitch-free.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State, counter and all registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      stb_q    <= 1'b0;
      adr_q    <= 10'h000;
      wdat_q   <= 32'h0000_0000;
      sel_q    <= 4'h0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdat_q   <= 32'h0000_0000;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      stb_q    <= stb_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      rvalid_q <= rvalid_d;
      rdat_q   <= rdat_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
    end
  end

  assign cmd_ready_o   = ready_q;
  assign busy_o        = busy_q;
  assign m_wb_cyc_o    = stb_q;
  assign m_wb_stb_o    = stb_q;
  assign m_wb_adr_o    = adr_q;
  assign m_wb_dat_o    = wdat_q;
  assign m_wb_sel_o    = sel_q;
  assign m_wb_we_o     = we_q;
  assign rsp_valid_o   = rvalid_q;
  assign rsp_dat_o     = rdat_q;
  assign rsp_err_o     = rerr_q;
  assign rsp_timeout_o = rto_q;

endmodule

// File: tb/tb_wb_cfg_master.sv
module tb_wb_cfg_master;

  localparam int TO = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_SILENT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [9:0]  cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_to;
  logic [31:0] rsp_dat;
  logic [11:2] wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, busy;

  int checks = 0;
  int errors = 0;

  wb_cfg_master #(.TIMEOUT_CYC(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_to),
    .m_wb_adr_o(wb_adr), .m_wb_dat_o(wb_dat_o), .m_wb_sel_o(wb_sel),
    .m_wb_we_o(wb_we), .m_wb_cyc_o(wb_cyc), .m_wb_stb_o(wb_stb),
    .m_wb_dat_i(wb_dat_i), .m_wb_ack_i(wb_ack), .m_wb_err_i(wb_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [9:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          waits;   // stb cycles before the slave answers
    int          kind;    // K_ACK / K_ERR / K_BOTH / K_SILENT
    logic [31:0] rdata;
    int          hold;    // cycles rsp_ready stays low
    logic        late;    // drive a stray ack after the response
    int          exp_stb;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_dat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [9:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat, input int waits, input int kind,
                              input logic [31:0] rdata, input int hold, input logic late,
                              input int exp_stb, input logic exp_err, input logic exp_to,
                              input logic [31:0] exp_dat);
    vec_t v;
    v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.waits = waits; v.kind = kind;
    v.rdata = rdata; v.hold = hold; v.late = late; v.exp_stb = exp_stb;
    v.exp_err = exp_err; v.exp_to = exp_to; v.exp_dat = exp_dat;
    return v;
  endfunction

  // Reference: the slave answers in stb cycle (waits+1) unless the timeout budget
  // of TO stb cycles runs out first; err/err+ack give an error, only a clean ack on
  // a read returns data.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit timed;
    timed     = (v.kind == K_SILENT) || (v.waits + 1 > TO);
    r.exp_stb = timed ? TO : v.waits + 1;
    r.exp_to  = timed;
    r.exp_err = timed || (v.kind == K_ERR) || (v.kind == K_BOTH);
    r.exp_dat = (!timed && v.kind == K_ACK && !v.we) ? v.rdata : 32'h0;
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int guard = 0;
    int k = 0;
    bit bus_ok = 1'b1;
    bit hold_ok = 1'b1;
    logic [33:0] rsp_snap;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " cmd_ready before issue"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_sel = v.sel; cmd_dat = v.dat;
    @(posedge clk);
    @(negedge clk);
    // Scramble the command inputs so only latched values can pass the bus checks.
    cmd_valid = 1'b0; cmd_we = ~v.we; cmd_adr = ~v.adr; cmd_sel = ~v.sel; cmd_dat = $urandom();
    while (wb_stb && k < 80) begin
      if (wb_cyc !== 1'b1 || wb_adr !== v.adr || wb_sel !== v.sel || wb_we !== v.we ||
          wb_dat_o !== (v.we ? v.dat : 32'h0) || busy !== 1'b1 || cmd_ready !== 1'b0 ||
          rsp_valid !== 1'b0)
        bus_ok = 1'b0;
      if (v.kind != K_SILENT && k == v.waits) begin
        wb_ack   = (v.kind == K_ACK) || (v.kind == K_BOTH);
        wb_err   = (v.kind == K_ERR) || (v.kind == K_BOTH);
        wb_dat_i = v.rdata;
      end else begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom();
      end
      k++;
      @(negedge clk);
    end
    wb_ack = 1'b0; wb_err = 1'b0;
    chk({tag, " bus signals stable"}, bus_ok, 1);
    chk({tag, " stb cycles"}, k, v.exp_stb);
    chk({tag, " cyc low after"}, wb_cyc, 0);
    chk({tag, " bus outputs cleared"}, {wb_adr, wb_dat_o, wb_sel, wb_we}, 0);
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " rsp_err"}, rsp_err, v.exp_err);
    chk({tag, " rsp_timeout"}, rsp_to, v.exp_to);
    chk({tag, " rsp_dat"}, rsp_dat, v.exp_dat);
    rsp_snap = {rsp_valid, rsp_err, rsp_dat};
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_err, rsp_dat} !== rsp_snap || cmd_ready !== 1'b0 || busy !== 1'b1)
        hold_ok = 1'b0;
    end
    if (v.hold > 0) chk({tag, " response held"}, hold_ok, 1);
    rsp_ready = 1'b1;
    if (v.late) wb_ack = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " released"}, {rsp_valid, rsp_err, rsp_to, busy, cmd_ready}, 5'b00001);
    if (v.late) begin
      @(negedge clk);
      wb_ack = 1'b0;
      chk({tag, " late ack ignored"}, {rsp_valid, wb_stb, busy}, 3'b000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int acc[$];

    // Expected columns are worked out by hand for TIMEOUT_CYC=4.
    tbl[0] = mk(1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 2, K_ACK,  32'hCAFEF00D, 0, 1'b0, 3, 1'b0, 1'b0, 32'h0);
    tbl[1] = mk(1'b0, 10'h3FF, 4'hF, 32'h11111111, 0, K_ACK,  32'h12345678, 0, 1'b0, 1, 1'b0, 1'b0, 32'h12345678);
    tbl[2] = mk(1'b0, 10'h055, 4'h3, 32'h0,        1, K_BOTH, 32'hAAAA5555, 0, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    tbl[3] = mk(1'b0, 10'h001, 4'h1, 32'h0,        0, K_SILENT, 32'h5A5A5A5A, 0, 1'b1, 4, 1'b1, 1'b1, 32'h0);
    tbl[4] = mk(1'b1, 10'h200, 4'h5, 32'h0BADF00D, 0, K_ACK,  32'h77777777, 5, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    tbl[5] = mk(1'b0, 10'h123, 4'hC, 32'h0,        3, K_ERR,  32'h99999999, 1, 1'b0, 4, 1'b1, 1'b0, 32'h0);
    tbl[6] = mk(1'b0, 10'h2A5, 4'hF, 32'h0,        3, K_ACK,  32'h87654321, 0, 1'b0, 4, 1'b0, 1'b0, 32'h87654321);
    tbl[7] = mk(1'b0, 10'h0F0, 4'hF, 32'h0,        4, K_ACK,  32'h13579BDF, 2, 1'b1, 4, 1'b1, 1'b1, 32'h0);

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 10'h0; cmd_sel = 4'h0;
    cmd_dat = 32'h0; rsp_ready = 1'b0; wb_dat_i = 32'h0; wb_ack = 1'b0; wb_err = 1'b0;
    #2;
    chk("reset outputs", {cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_to, wb_adr, wb_dat_o,
                          wb_sel, wb_we, wb_cyc, wb_stb, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Randomised transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.we = 1'(($urandom() & 1));
      v.adr = 10'($urandom()); v.sel = 4'($urandom()); v.dat = $urandom();
      v.waits = $urandom_range(0, 5); v.kind = $urandom_range(0, 3);
      v.rdata = $urandom(); v.hold = $urandom_range(0, 3);
      v.late = 1'(($urandom() & 1));
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    // Back-to-back commands with a zero-wait slave and rsp_ready tied high.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 10'h044; cmd_sel = 4'hF; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (cmd_ready) acc.push_back(c);
      wb_ack = wb_stb; wb_dat_i = $urandom();
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (4) begin
      wb_ack = wb_stb;
      @(negedge clk);
    end
    wb_ack = 1'b0; rsp_ready = 1'b0;
    chk("b2b accept count", acc.size(), 4);
    for (int j = 1; j < acc.size(); j++)
      chk($sformatf("b2b spacing %0d", j), acc[j] - acc[j-1], 3);
    chk("b2b drained", {busy, cmd_ready}, 2'b01);

    // Reset while the strobe is up, then a normal read afterwards.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 10'h155; cmd_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre-reset stb", wb_stb, 1);
    rst_n = 1'b0;
    #1;
    chk("reset mid-bus", {wb_cyc, wb_stb, busy, cmd_ready, rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(mk(1'b0, 10'h0AA, 4'hF, 32'h0, 1, K_ACK, 32'hFEEDFACE, 0, 1'b0,
               2, 1'b0, 1'b0, 32'hFEEDFACE), "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
